// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin front end for a single-port RAM with
// registered read data. Each access takes a fixed IDLE -> ACCESS -> DONE walk:
// the grant edge latches the winner's request, ACCESS presents it to the RAM,
// DONE returns the RAM read data with a one-cycle ready pulse.
//
// Optional build macro: MEM_ARBITER_RANGE_CHECK_EN
//   When defined, accesses whose word address is WORDS or above are
//   suppressed (no write enables, read data forced to 0) with unchanged timing.
module mem_arbiter #(
  parameter int unsigned WORDS = 256
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic        m1_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m0_wstrb,
  input  logic [3:0]  m1_wstrb,
  output logic        m0_ready,
  output logic        m1_ready,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic [3:0]  ram_wen,
  output logic [21:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Word-count bound widened by one bit so WORDS = 2^22 is representable.
  localparam logic [22:0] WORDS_W = 23'(WORDS);

  state_e      state_q, state_d;
  logic        last_q,  last_d;   // id granted most recently (1 = m1)
  logic        id_q,    id_d;     // id of the access in flight
  logic [21:0] addr_q,  addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;

  logic any_vld;
  logic gnt;        // winner of this cycle's arbitration (1 = m1)
  logic in_range;
  logic acc_ok;     // access allowed to touch the RAM / return data

  assign any_vld = m0_valid | m1_valid;
  // On a tie the requester not served last wins; otherwise the lone requester.
  assign gnt     = (m0_valid & m1_valid) ? ~last_q : m1_valid;

  assign in_range = ({1'b0, addr_q} < WORDS_W);

`ifdef MEM_ARBITER_RANGE_CHECK_EN
  assign acc_ok = in_range;
`else
  // Out-of-range word addresses go straight through; the RAM decides.
  assign acc_ok = 1'b1;
  logic unused_range;
  assign unused_range = in_range;
`endif

  // Only addr[23:2] forms the word address; the remaining bits are don't-care.
  logic unused_addr;
  assign unused_addr = ^{m0_addr[31:24], m0_addr[1:0], m1_addr[31:24], m1_addr[1:0]};

  // Next-state and request-latch logic; requests are only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    case (state_q)
      IDLE: begin
        if (any_vld) begin
          state_d = ACCESS;
          id_d    = gnt;
          last_d  = gnt;
          if (gnt) begin
            addr_d  = m1_addr[23:2];
            wdata_d = m1_wdata;
            wstrb_d = m1_wstrb;
          end else begin
            addr_d  = m0_addr[23:2];
            wdata_d = m0_wdata;
            wstrb_d = m0_wstrb;
          end
        end
      end
      ACCESS:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and latched-request registers; reset drops any in-flight access.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      last_q  <= 1'b1;  // so m0 wins the first tie after reset
      id_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  // Output decode: RAM port driven from the latch, ready/rdata only in DONE.
  // Write enables are gated by resetn so a reset edge can never write the RAM.
  always_comb begin
    ram_wen   = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    m0_ready  = 1'b0;
    m1_ready  = 1'b0;
    m0_rdata  = '0;
    m1_rdata  = '0;
    busy      = (state_q != IDLE);
    case (state_q)
      ACCESS: begin
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
        ram_wen   = (resetn && acc_ok) ? wstrb_q : 4'b0000;
      end
      DONE: begin
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
        if (id_q) begin
          m1_ready = 1'b1;
          m1_rdata = acc_ok ? ram_rdata : 32'h0;
        end else begin
          m0_ready = 1'b1;
          m0_rdata = acc_ok ? ram_rdata : 32'h0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction table plus hand sequences for
// round-robin streaming, reset mid-access and input changes after grant.
// A byte-enable RAM with registered read lives in the bench.
module tb_mem_arbiter;

  logic        clk;
  logic        resetn;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic [3:0]  ram_wen;
  logic [21:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        busy;

  int checks;
  int failures;

  mem_arbiter #(.WORDS(256)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m1_valid(m1_valid),
    .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_wstrb(m0_wstrb), .m1_wstrb(m1_wstrb),
    .m0_ready(m0_ready), .m1_ready(m1_ready),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench RAM: 1024 words indexed by the low word-address bits.
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (ram_wen[b]) mem[ram_addr[9:0]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    ram_rdata <= mem[ram_addr[9:0]];
  end

  function automatic logic in_rng(input logic [21:0] w);
`ifdef MEM_ARBITER_RANGE_CHECK_EN
    return (w < 22'd256);
`else
    return 1'b1;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        v0, v1;
    logic [31:0] a0, a1, d0, d1;
    logic [3:0]  s0, s1;
    logic        id;    // expected winner
    logic [31:0] rd;    // expected read data (unguarded build)
    logic        crd;   // compare read data
  } vec_t;

  function automatic vec_t mk(input logic v0, input logic [31:0] a0, input logic [31:0] d0,
                              input logic [3:0] s0, input logic v1, input logic [31:0] a1,
                              input logic [31:0] d1, input logic [3:0] s1, input logic id,
                              input logic [31:0] rd, input logic crd);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.d0 = d0; v.s0 = s0;
    v.v1 = v1; v.a1 = a1; v.d1 = d1; v.s1 = s1;
    v.id = id; v.rd = rd; v.crd = crd;
    return v;
  endfunction

  task automatic idle_inputs();
    m0_valid = 0; m1_valid = 0;
    m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0; m0_wstrb = 0; m1_wstrb = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    resetn = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_ready"}, 32'({m1_ready, m0_ready}), 0);
    chk({tag, "_rdata"}, m0_rdata | m1_rdata, 0);
    chk({tag, "_ram_wen"}, 32'(ram_wen), 0);
    chk({tag, "_ram_addr"}, 32'(ram_addr), 0);
    chk({tag, "_ram_wdata"}, ram_wdata, 0);
  endtask

  // One complete transaction from IDLE: grant, ACCESS checks, DONE checks, back to IDLE.
  task automatic run_vec(input vec_t v, input string tag);
    logic [21:0] wa;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic [31:0] erd;
    m0_valid = v.v0; m0_addr = v.a0; m0_wdata = v.d0; m0_wstrb = v.s0;
    m1_valid = v.v1; m1_addr = v.a1; m1_wdata = v.d1; m1_wstrb = v.s1;
    wa = v.id ? v.a1[23:2] : v.a0[23:2];
    wd = v.id ? v.d1 : v.d0;
    ws = v.id ? v.s1 : v.s0;
    erd = in_rng(wa) ? v.rd : 32'h0;
    @(posedge clk); @(negedge clk);
    chk({tag, "_acc_busy"}, 32'(busy), 1);
    chk({tag, "_acc_addr"}, 32'(ram_addr), 32'(wa));
    chk({tag, "_acc_wen"}, 32'(ram_wen), in_rng(wa) ? 32'(ws) : 0);
    chk({tag, "_acc_wdata"}, ram_wdata, wd);
    chk({tag, "_acc_ready"}, 32'({m1_ready, m0_ready}), 0);
    @(posedge clk); @(negedge clk);
    chk({tag, "_done_ready"}, 32'({m1_ready, m0_ready}), v.id ? 2 : 1);
    chk({tag, "_done_wen"}, 32'(ram_wen), 0);
    if (v.crd) chk({tag, "_done_rdata"}, v.id ? m1_rdata : m0_rdata, erd);
    chk({tag, "_done_other_rdata"}, v.id ? m0_rdata : m1_rdata, 0);
    idle_inputs();
    @(posedge clk); @(negedge clk);
    chk({tag, "_idle_busy"}, 32'(busy), 0);
    chk({tag, "_idle_ready"}, 32'({m1_ready, m0_ready}), 0);
  endtask

  vec_t tbl[13];

  initial begin
    logic [1:0] exp_rdy;
    checks = 0;
    failures = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    idle_inputs();
    resetn = 0;

    tbl[0]  = mk(1, 32'h40,       32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 32'h40,       0, 0,             0, 0, 0, 0, 0, 32'hDEADBEEF, 1);
    tbl[2]  = mk(0, 0, 0, 0, 1, 32'h80,       32'h11223344, 4'hF, 1, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 1, 32'h80,       32'h000000AA, 4'h1, 1, 0, 0);
    tbl[4]  = mk(1, 32'h80,       0, 0,             0, 0, 0, 0, 0, 32'h112233AA, 1);
    tbl[5]  = mk(1, 32'h40,       0, 0,             1, 32'h80, 0, 0, 1, 32'h112233AA, 1);
    tbl[6]  = mk(1, 32'h40,       0, 0,             1, 32'h80, 0, 0, 0, 32'hDEADBEEF, 1);
    tbl[7]  = mk(0, 0, 0, 0, 1, 32'h1000_0084, 32'hCAFEF00D, 4'hC, 1, 0, 0);
    tbl[8]  = mk(1, 32'h87,       0, 0,             0, 0, 0, 0, 0, 32'hCAFE0000, 1);
    tbl[9]  = mk(1, 32'h00FFFFFC, 32'h00000001, 4'hF, 0, 0, 0, 0, 0, 0, 0);
    tbl[10] = mk(1, 32'h00FFFFFC, 0, 0,             0, 0, 0, 0, 0, 32'h00000001, 1);
    tbl[11] = mk(0, 0, 0, 0, 1, 32'h400,      32'h12345678, 4'hF, 1, 0, 0);
    tbl[12] = mk(0, 0, 0, 0, 1, 32'h400,      0, 0, 1, 32'h12345678, 1);

    // Reset state, held in reset and just after release
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("in_reset");
    resetn = 1;
    @(posedge clk); @(negedge clk);
    chk_all_zero("post_reset");

    // Transaction table
    for (int i = 0; i < 13; i++) run_vec(tbl[i], $sformatf("v%0d", i));

    // Both requesters held continuously from reset: m0, m1, m0, m1 every 3 cycles
    do_reset();
    m0_valid = 1; m0_addr = 32'h40;
    m1_valid = 1; m1_addr = 32'h80;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); @(negedge clk);
      exp_rdy = (k % 3 == 2) ? (((k / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      chk($sformatf("rr_k%0d_ready", k), 32'({m1_ready, m0_ready}), 32'(exp_rdy));
      chk($sformatf("rr_k%0d_m0_rdata", k), m0_rdata, exp_rdy[0] ? 32'hDEADBEEF : 0);
      chk($sformatf("rr_k%0d_m1_rdata", k), m1_rdata, exp_rdy[1] ? 32'h112233AA : 0);
    end
    idle_inputs();
    @(posedge clk); @(negedge clk);

    // Reset asserted during ACCESS of a write: no write, no ready, all zero after
    m0_valid = 1; m0_addr = 32'h40; m0_wdata = 32'h55555555; m0_wstrb = 4'hF;
    @(posedge clk); @(negedge clk);
    chk("abort_pre_wen", 32'(ram_wen), 32'hF);
    resetn = 0;
    #1;
    chk("abort_wen_forced", 32'(ram_wen), 0);
    @(posedge clk); @(negedge clk);
    idle_inputs();
    chk_all_zero("abort_after");
    resetn = 1;
    @(posedge clk); @(negedge clk);
    chk_all_zero("abort_release");
    run_vec(mk(1, 32'h40, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 1), "abort_readback");

    // m1 changes its request during ACCESS: RAM sees the grant-time values
    m1_valid = 1; m1_addr = 32'hC0; m1_wdata = 32'h0BADF00D; m1_wstrb = 4'hF;
    @(posedge clk); @(negedge clk);
    m1_addr = 32'h100; m1_wdata = 32'hFFFFFFFF; m1_wstrb = 4'h0;
    #1;
    chk("chg_addr", 32'(ram_addr), 32'h30);
    chk("chg_wdata", ram_wdata, 32'h0BADF00D);
    chk("chg_wen", 32'(ram_wen), 32'hF);
    @(posedge clk); @(negedge clk);
    chk("chg_ready", 32'({m1_ready, m0_ready}), 2);
    idle_inputs();
    @(posedge clk); @(negedge clk);
    run_vec(mk(1, 32'hC0,  0, 0, 0, 0, 0, 0, 0, 32'h0BADF00D, 1), "chg_read_latched");
    run_vec(mk(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1), "chg_read_changed");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
